multdiv_cycle_ctrl: RTL and testbench

//  Parametrised iteration controller for the multi-cycle multiplier/divider.

---
 rtl/multdiv_pkg.sv | 22 ++
 rtl/cycle_counter.sv | 40 ++++
 rtl/dffe_ref.sv | 20 ++
 rtl/multdiv_cycle_ctrl.sv | 129 ++++++++++++
 tb/tb_multdiv_cycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multi-cycle multiplier/divider control slice.
// Holds the controller state encoding, the default iteration counts and a
// helper used to validate counter width against a terminal count.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 6;
  localparam int DEF_MULT_CYCLES = 17;
  localparam int DEF_DIV_CYCLES  = 33;

  // A terminal count is usable when it is at least one and the counter can
  // hold the value TC itself (the count parks on TC during DONE).
  function automatic bit tc_fits(input int tc, input int width);
    return (tc >= 1) && (tc < (1 << width));
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Iteration counter built from dffe_ref bits and a ripple-AND incrementer.
// Also serves the datapath's shift-count logic.
// Ports: clk, clear (async, active-high), advance (count+1),
//        load_zero (synchronous return to zero, wins over advance),
//        count (current value).
module cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             advance,
  input  logic             load_zero,
  output logic [CNT_W-1:0] count
);

  // carry[i] is high when every bit below i is set, i.e. bit i toggles.
  logic [CNT_W-1:0] carry;
  logic [CNT_W-1:0] d;
  logic             en;

  assign carry[0] = 1'b1;
  assign en       = advance | load_zero;

  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_bit
      if (gi < CNT_W - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & count[gi];
      end
      assign d[gi] = ~load_zero & (count[gi] ^ carry[gi]);
      dffe_ref u_ff (
        .clk (clk),
        .clr (clear),
        .en  (en),
        .d   (d[gi]),
        .q   (count[gi])
      );
    end
  endgenerate

endmodule

// File: rtl/dffe_ref.sv
// Single-bit D flip-flop with write enable and asynchronous clear.
// Ports: clk (rising edge), clr (async, active-high), en (write enable),
//        d (next value), q (stored bit).
module dffe_ref (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_cycle_ctrl.sv
// Iteration controller for the multi-cycle multiplier/divider.
// A start pulse latches the op type and runs the counter up to the op's
// terminal count (TC); enable stalls, abort cancels. A one-cycle
// data_resultRDY pulse marks completion.
// Ports: clock, ctrl_reset (async, active-high), ctrl_MULT / ctrl_DIV (start
//        pulses, DIV wins), ctrl_abort, enable (advance qualifier),
//        busy (RUN), first_cycle (RUN with count==0), op_is_div (latched op),
//        count (iteration index), data_resultRDY (DONE).
module multdiv_cycle_ctrl
  import multdiv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int RESTART_EN  = 0
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_abort,
  input  logic             enable,
  output logic             busy,
  output logic             first_cycle,
  output logic             op_is_div,
  output logic [CNT_W-1:0] count,
  output logic             data_resultRDY
);

  generate
    if (!tc_fits(MULT_CYCLES, CNT_W) || !tc_fits(DIV_CYCLES, CNT_W)) begin : g_bad_params
      $error("multdiv_cycle_ctrl: cycle counts must be >= 1 and < 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] MULT_TC = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(DIV_CYCLES);

  state_t           state;
  state_t           state_next;
  logic             start;
  logic             advance;
  logic             load_zero;
  logic             latch_op;
  logic [CNT_W-1:0] tc;
  logic [CNT_W-1:0] tc_last;
  logic             at_last;

  assign start   = ctrl_MULT | ctrl_DIV;
  assign tc      = op_is_div ? DIV_TC : MULT_TC;
  assign tc_last = tc - CNT_W'(1);
  assign at_last = (count == tc_last);

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    load_zero  = 1'b0;
    latch_op   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !ctrl_abort) begin
          state_next = ST_RUN;
          load_zero  = 1'b1;
          latch_op   = 1'b1;
        end
      end
      ST_RUN: begin
        if (ctrl_abort) begin
          state_next = ST_IDLE;
          load_zero  = 1'b1;
        end else if (start && (RESTART_EN != 0)) begin
          load_zero = 1'b1;
          latch_op  = 1'b1;
        end else if (enable) begin
          // The final increment lands the count on TC, which DONE holds.
          advance = 1'b1;
          if (at_last) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start here chains straight into the next op with no IDLE gap.
        load_zero = 1'b1;
        if (start && !ctrl_abort) begin
          state_next = ST_RUN;
          latch_op   = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        load_zero  = 1'b1;
      end
    endcase
  end

  // busy and data_resultRDY are registered copies of the next-state decode,
  // so they carry no combinational path from the inputs.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state          <= ST_IDLE;
      op_is_div      <= 1'b0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_next;
      busy           <= (state_next == ST_RUN);
      data_resultRDY <= (state_next == ST_DONE);
      if (latch_op) begin
        op_is_div <= ctrl_DIV;
      end
    end
  end

  cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clock),
    .clear     (ctrl_reset),
    .advance   (advance),
    .load_zero (load_zero),
    .count     (count)
  );

  assign first_cycle = busy & (count == '0);

endmodule

// File: tb/tb_multdiv_cycle_ctrl.sv
// Self-checking bench for multdiv_cycle_ctrl. Instance 0 uses the default
// parameters (RESTART_EN=0); instance 1 uses MULT=1, DIV=8, RESTART_EN=1.
// Completion pulses are checked by a scoreboard; everything else inline.
module tb_multdiv_cycle_ctrl;

  typedef struct {
    int dut;
    bit mult;
    bit div;
    int stall_at;
    int stall_len;
    bit exp_div;
    int exp_tc;
  } vec_t;

  typedef struct {
    int cyc;
    bit is_div;
    int tc;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst;
  logic       mult_i[2];
  logic       div_i[2];
  logic       abort_i[2];
  logic       en_i[2];
  logic       busy_o[2];
  logic       first_o[2];
  logic       isdiv_o[2];
  logic       rdy_o[2];
  logic [5:0] count_o[2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[7];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multdiv_cycle_ctrl dut0 (
    .clock          (clock),
    .ctrl_reset     (rst),
    .ctrl_MULT      (mult_i[0]),
    .ctrl_DIV       (div_i[0]),
    .ctrl_abort     (abort_i[0]),
    .enable         (en_i[0]),
    .busy           (busy_o[0]),
    .first_cycle    (first_o[0]),
    .op_is_div      (isdiv_o[0]),
    .count          (count_o[0]),
    .data_resultRDY (rdy_o[0])
  );

  multdiv_cycle_ctrl #(
    .CNT_W       (6),
    .MULT_CYCLES (1),
    .DIV_CYCLES  (8),
    .RESTART_EN  (1)
  ) dut1 (
    .clock          (clock),
    .ctrl_reset     (rst),
    .ctrl_MULT      (mult_i[1]),
    .ctrl_DIV       (div_i[1]),
    .ctrl_abort     (abort_i[1]),
    .enable         (en_i[1]),
    .busy           (busy_o[1]),
    .first_cycle    (first_o[1]),
    .op_is_div      (isdiv_o[1]),
    .count          (count_o[1]),
    .data_resultRDY (rdy_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input int c, input bit isdiv, input int tc);
    exp_t e;
    e.cyc = c;
    e.is_div = isdiv;
    e.tc = tc;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Called at a negedge; the start is sampled by edge e and we return at the
  // negedge that follows it.
  task automatic pulse_start(input int d, input bit m, input bit v, output int e);
    mult_i[d] = m;
    div_i[d] = v;
    e = cyc + 1;
    @(negedge clock);
    mult_i[d] = 1'b0;
    div_i[d] = 1'b0;
  endtask

  task automatic wait_count(input int d, input int val, input string name);
    int n = 0;
    while (!(busy_o[d] && count_o[d] == 6'(val)) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, count=%0d busy=%0d, expected count %0d", name, count_o[d], busy_o[d], val);
    end
  endtask

  task automatic wait_idle(input int d, input string name);
    int n = 0;
    while ((busy_o[d] || rdy_o[d]) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting for idle, busy=%0d", name, busy_o[d]);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   e;
    v = vecs[i];
    pulse_start(v.dut, v.mult, v.div, e);
    push_exp(v.dut, e + v.exp_tc + v.stall_len, v.exp_div, v.exp_tc);
    chk($sformatf("vec%0d_first_cycle", i), first_o[v.dut], 1);
    chk($sformatf("vec%0d_count0", i), count_o[v.dut], 0);
    chk($sformatf("vec%0d_op_is_div", i), isdiv_o[v.dut], v.exp_div);
    if (v.stall_at >= 0) begin
      wait_count(v.dut, v.stall_at, $sformatf("vec%0d_stall_wait", i));
      en_i[v.dut] = 1'b0;
      repeat (v.stall_len) begin
        @(negedge clock);
        chk($sformatf("vec%0d_stall_hold", i), count_o[v.dut], v.stall_at);
        chk($sformatf("vec%0d_stall_busy", i), busy_o[v.dut], 1);
      end
      en_i[v.dut] = 1'b1;
    end
    wait_idle(v.dut, $sformatf("vec%0d_idle", i));
    $display("vec %0d: dut%0d mult=%0d div=%0d stall@%0d x%0d tc=%0d done", i, v.dut, v.mult, v.div,
             v.stall_at, v.stall_len, v.exp_tc);
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rdy_o[d]) begin
          ok = 1'b0;
          if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            ok = 1'b1;
          end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            ok = 1'b1;
          end
          if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_rdy dut%0d: data_resultRDY=1 at cycle %0d, expected no pulse", d, cyc);
          end else begin
            chk($sformatf("rdy_cycle_dut%0d", d), cyc, e.cyc);
            chk($sformatf("rdy_op_is_div_dut%0d", d), isdiv_o[d], e.is_div);
            chk($sformatf("rdy_count_dut%0d", d), count_o[d], e.tc);
            chk($sformatf("rdy_busy_dut%0d", d), busy_o[d], 0);
          end
        end
      end
    end
  end

  initial begin
    int e;
    int e2;
    vecs[0] = '{0, 1'b0, 1'b1, -1, 0, 1'b1, 33};
    vecs[1] = '{0, 1'b1, 1'b0, -1, 0, 1'b0, 17};
    vecs[2] = '{0, 1'b0, 1'b1, 10, 5, 1'b1, 33};
    vecs[3] = '{0, 1'b1, 1'b1, -1, 0, 1'b1, 33};
    vecs[4] = '{1, 1'b1, 1'b0, -1, 0, 1'b0, 1};
    vecs[5] = '{1, 1'b0, 1'b1, 3, 2, 1'b1, 8};
    vecs[6] = '{0, 1'b1, 1'b0, 0, 3, 1'b0, 17};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mult_i[d] = 1'b0;
      div_i[d] = 1'b0;
      abort_i[d] = 1'b0;
      en_i[d] = 1'b1;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_busy_dut%0d", d), busy_o[d], 0);
      chk($sformatf("reset_first_dut%0d", d), first_o[d], 0);
      chk($sformatf("reset_rdy_dut%0d", d), rdy_o[d], 0);
      chk($sformatf("reset_count_dut%0d", d), count_o[d], 0);
      chk($sformatf("reset_op_is_div_dut%0d", d), isdiv_o[d], 0);
    end
    rst = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Abort mid-run, then a start coinciding with abort in IDLE.
    pulse_start(0, 1'b0, 1'b1, e);
    wait_count(0, 20, "abort_wait");
    abort_i[0] = 1'b1;
    @(negedge clock);
    chk("abort_busy", busy_o[0], 0);
    chk("abort_count", count_o[0], 0);
    mult_i[0] = 1'b1;
    @(negedge clock);
    mult_i[0] = 1'b0;
    abort_i[0] = 1'b0;
    chk("abort_start_ignored", busy_o[0], 0);
    repeat (40) @(negedge clock);
    $display("seq abort: done");

    // Back-to-back: MULT start sampled in the DONE cycle of a DIV.
    pulse_start(0, 1'b0, 1'b1, e);
    push_exp(0, e + 33, 1'b1, 33);
    begin
      int n = 0;
      while (!rdy_o[0] && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("b2b_reached_done", rdy_o[0], 1);
    end
    pulse_start(0, 1'b1, 1'b0, e2);
    push_exp(0, e2 + 17, 1'b0, 17);
    chk("b2b_no_gap_busy", busy_o[0], 1);
    chk("b2b_count0", count_o[0], 0);
    chk("b2b_op_is_div", isdiv_o[0], 0);
    wait_idle(0, "b2b_idle");
    $display("seq back-to-back: done");

    // Start while RUN is ignored when RESTART_EN=0.
    pulse_start(0, 1'b0, 1'b1, e);
    push_exp(0, e + 33, 1'b1, 33);
    wait_count(0, 5, "norestart_wait");
    mult_i[0] = 1'b1;
    @(negedge clock);
    mult_i[0] = 1'b0;
    chk("norestart_count", count_o[0], 6);
    chk("norestart_op_is_div", isdiv_o[0], 1);
    wait_idle(0, "norestart_idle");
    $display("seq no-restart: done");

    // Start while RUN restarts when RESTART_EN=1 (new op is a 1-cycle MULT).
    pulse_start(1, 1'b0, 1'b1, e);
    wait_count(1, 5, "restart_wait");
    pulse_start(1, 1'b1, 1'b0, e2);
    push_exp(1, e2 + 1, 1'b0, 1);
    chk("restart_count", count_o[1], 0);
    chk("restart_op_is_div", isdiv_o[1], 0);
    chk("restart_first", first_o[1], 1);
    wait_idle(1, "restart_idle");
    $display("seq restart: done");

    // Asynchronous reset between edges mid-run.
    pulse_start(0, 1'b0, 1'b1, e);
    wait_count(0, 8, "areset_wait");
    #2 rst = 1'b1;
    #1;
    chk("areset_busy", busy_o[0], 0);
    chk("areset_count", count_o[0], 0);
    chk("areset_first", first_o[0], 0);
    chk("areset_op_is_div", isdiv_o[0], 0);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("areset_idle_after", busy_o[0], 0);
    repeat (40) @(negedge clock);
    $display("seq async reset: done");

    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
